// File: rtl/bp_table_ctrl.sv
// Access controller for a 256-entry 2-bit saturating-counter branch-prediction table.
// Arbitrates one single-port RAM between fetch lookups, buffered commit updates and the init walk.
module bp_table_ctrl #(
  parameter int         QDEPTH    = 4,
  parameter int         STARVE_TH = 3,
  parameter logic [1:0] INIT_VAL  = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       in_clear,
  input  logic       in_fetcher_valid,
  input  logic [7:0] in_fetcher_tag,
  output logic       out_fetcher_ready,
  output logic       out_fetcher_res_valid,
  output logic       out_fetcher_jump_res,
  input  logic       in_rob_bp_res,
  input  logic [7:0] in_rob_tag,
  input  logic       in_rob_jump_res,
  output logic       out_rob_full,
  output logic       out_overflow,
  output logic       out_init_done,
  output logic       out_tbl_en,
  output logic       out_tbl_we,
  output logic [7:0] out_tbl_addr,
  output logic [1:0] out_tbl_wdata,
  input  logic [1:0] in_tbl_rdata
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_UPD_WR = 2'd2
  } state_e;

  state_e          state_q;
  logic [7:0]      init_addr_q;
  logic [8:0]      fifo_q [QDEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            full_q;
  logic            overflow_q;
  logic            init_done_q;
  logic            res_valid_q;
  logic [7:0]      upd_tag_q;
  logic            upd_jmp_q;

  logic            go_s;
  logic            fifo_full_s;
  logic            upd_fire_s;
  logic            fetch_rdy_s;
  logic            accept_s;
  logic            push_s;
  logic            tbl_en_s;
  logic            tbl_we_s;
  logic [7:0]      tbl_addr_s;
  logic [1:0]      tbl_wdata_s;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] r;
    if (taken) begin
      r = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      r = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return r;
  endfunction

  // rst is folded in so no strobe leaks out while reset is held in INIT
  assign go_s        = rst & rdy & ~in_clear;
  assign fifo_full_s = (count_q == CW'(QDEPTH));
  assign upd_fire_s  = go_s && (state_q == S_RUN) && (count_q != '0) &&
                       ((count_q >= CW'(STARVE_TH)) || !in_fetcher_valid);
  assign fetch_rdy_s = go_s && (state_q == S_RUN) && !upd_fire_s;
  assign accept_s    = fetch_rdy_s && in_fetcher_valid;
  assign push_s      = go_s && in_rob_bp_res && !fifo_full_s;

  // Next FIFO occupancy
  always_comb begin
    count_d = count_q;
    if (push_s && !upd_fire_s) begin
      count_d = count_q + CW'(1);
    end else if (upd_fire_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Table port strobes for the current cycle
  always_comb begin
    tbl_en_s    = 1'b0;
    tbl_we_s    = 1'b0;
    tbl_addr_s  = 8'h00;
    tbl_wdata_s = 2'b00;
    case (state_q)
      S_INIT: begin
        if (go_s) begin
          tbl_en_s    = 1'b1;
          tbl_we_s    = 1'b1;
          tbl_addr_s  = init_addr_q;
          tbl_wdata_s = INIT_VAL;
        end else begin
          tbl_en_s    = 1'b0;
        end
      end
      S_RUN: begin
        if (upd_fire_s) begin
          tbl_en_s   = 1'b1;
          tbl_addr_s = fifo_q[head_q][8:1];
        end else if (accept_s) begin
          tbl_en_s   = 1'b1;
          tbl_addr_s = in_fetcher_tag;
        end else begin
          tbl_en_s   = 1'b0;
        end
      end
      S_UPD_WR: begin
        if (go_s) begin
          tbl_en_s    = 1'b1;
          tbl_we_s    = 1'b1;
          tbl_addr_s  = upd_tag_q;
          tbl_wdata_s = sat_next(in_tbl_rdata, upd_jmp_q);
        end else begin
          tbl_en_s    = 1'b0;
        end
      end
      default: begin
        tbl_en_s = 1'b0;
      end
    endcase
  end

  // Controller state, FIFO and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      init_addr_q <= 8'h00;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      init_done_q <= 1'b0;
      res_valid_q <= 1'b0;
      upd_tag_q   <= 8'h00;
      upd_jmp_q   <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= 9'h000;
      end
    end else if (!rdy) begin
      res_valid_q <= 1'b0;
    end else if (in_clear) begin
      state_q     <= S_INIT;
      init_addr_q <= 8'h00;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      init_done_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= accept_s;
      count_q     <= count_d;
      full_q      <= (count_d == CW'(QDEPTH));
      if (push_s) begin
        fifo_q[tail_q] <= {in_rob_tag, in_rob_jump_res};
        tail_q         <= tail_q + PW'(1);
      end
      if (in_rob_bp_res && fifo_full_s) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        S_INIT: begin
          init_addr_q <= init_addr_q + 8'd1;
          if (init_addr_q == 8'hFF) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (upd_fire_s) begin
            head_q    <= head_q + PW'(1);
            upd_tag_q <= fifo_q[head_q][8:1];
            upd_jmp_q <= fifo_q[head_q][0];
            state_q   <= S_UPD_WR;
          end
        end
        S_UPD_WR: begin
          state_q <= S_RUN;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign out_fetcher_ready     = fetch_rdy_s;
  assign out_fetcher_res_valid = res_valid_q & rdy & ~in_clear;
  assign out_fetcher_jump_res  = out_fetcher_res_valid & in_tbl_rdata[1];
  assign out_rob_full          = full_q;
  assign out_overflow          = overflow_q;
  assign out_init_done         = init_done_q;
  assign out_tbl_en            = tbl_en_s;
  assign out_tbl_we            = tbl_we_s;
  assign out_tbl_addr          = tbl_addr_s;
  assign out_tbl_wdata         = tbl_wdata_s;

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Bench for bp_table_ctrl: RAM model, behavioural table/queue reference,
// per-cycle compare of every output plus directed literal checks.
module tb_bp_table_ctrl;

  localparam int         QDEPTH    = 4;
  localparam int         STARVE_TH = 3;
  localparam logic [1:0] INIT_V    = 2'b01;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdy = 1'b1;
  logic       in_clear = 1'b0;
  logic       in_fetcher_valid = 1'b0;
  logic [7:0] in_fetcher_tag = 8'h00;
  logic       in_rob_bp_res = 1'b0;
  logic [7:0] in_rob_tag = 8'h00;
  logic       in_rob_jump_res = 1'b0;
  logic       out_fetcher_ready, out_fetcher_res_valid, out_fetcher_jump_res;
  logic       out_rob_full, out_overflow, out_init_done;
  logic       out_tbl_en, out_tbl_we;
  logic [7:0] out_tbl_addr;
  logic [1:0] out_tbl_wdata;
  logic [1:0] rdata = 2'b00;
  logic [1:0] mem [256];

  int vectors = 0;
  int miscompares = 0;

  bp_table_ctrl #(.QDEPTH(QDEPTH), .STARVE_TH(STARVE_TH), .INIT_VAL(INIT_V)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_clear(in_clear),
    .in_fetcher_valid(in_fetcher_valid), .in_fetcher_tag(in_fetcher_tag),
    .out_fetcher_ready(out_fetcher_ready), .out_fetcher_res_valid(out_fetcher_res_valid),
    .out_fetcher_jump_res(out_fetcher_jump_res),
    .in_rob_bp_res(in_rob_bp_res), .in_rob_tag(in_rob_tag), .in_rob_jump_res(in_rob_jump_res),
    .out_rob_full(out_rob_full), .out_overflow(out_overflow), .out_init_done(out_init_done),
    .out_tbl_en(out_tbl_en), .out_tbl_we(out_tbl_we), .out_tbl_addr(out_tbl_addr),
    .out_tbl_wdata(out_tbl_wdata), .in_tbl_rdata(rdata)
  );

  always #5 clk = ~clk;

  // single-port RAM, 1-cycle read latency, output holds when not read
  initial for (int i = 0; i < 256; i++) mem[i] = 2'b00;
  always @(posedge clk) begin
    if (out_tbl_en) begin
      if (out_tbl_we) mem[out_tbl_addr] <= out_tbl_wdata;
      else rdata <= mem[out_tbl_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat_ref(input logic [1:0] c, input bit taken);
    int v;
    v = int'(c) + (taken ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v[1:0];
  endfunction

  // reference model: what the table should hold and what is in flight
  bit         m_init = 1'b1;
  int         m_init_addr = 0;
  bit         m_done = 1'b0;
  bit         m_wr = 1'b0;
  logic [7:0] m_wr_tag = 8'h00;
  bit         m_wr_taken = 1'b0;
  bit         m_res = 1'b0;
  bit         m_res_jmp = 1'b0;
  bit         m_full = 1'b0;
  bit         m_ovf = 1'b0;
  logic [8:0] m_q [$];
  logic [1:0] exp_tbl [256];
  initial for (int i = 0; i < 256; i++) exp_tbl[i] = 2'b00;

  task automatic model_restart();
    m_init = 1'b1; m_init_addr = 0; m_done = 1'b0; m_wr = 1'b0;
    m_res = 1'b0; m_full = 1'b0; m_ovf = 1'b0; m_q.delete();
  endtask

  always @(posedge clk) begin
    bit full0, upd, acc;
    logic [8:0] item;
    if (!rst) model_restart();
    else if (!rdy) m_res = 1'b0;
    else if (in_clear) model_restart();
    else begin
      full0 = (m_q.size() == QDEPTH);
      upd = 1'b0; acc = 1'b0;
      if (m_init) begin
        exp_tbl[m_init_addr] = INIT_V;
        m_init_addr++;
        if (m_init_addr == 256) begin m_init = 1'b0; m_done = 1'b1; end
      end else if (m_wr) begin
        exp_tbl[m_wr_tag] = sat_ref(exp_tbl[m_wr_tag], m_wr_taken);
        m_wr = 1'b0;
      end else begin
        upd = (m_q.size() > 0) && ((m_q.size() >= STARVE_TH) || !in_fetcher_valid);
        if (upd) begin
          item = m_q.pop_front();
          m_wr = 1'b1; m_wr_tag = item[8:1]; m_wr_taken = item[0];
        end else acc = in_fetcher_valid;
      end
      m_res = acc;
      if (acc) m_res_jmp = exp_tbl[in_fetcher_tag][1];
      if (in_rob_bp_res) begin
        if (full0) m_ovf = 1'b1;
        else m_q.push_back({in_rob_tag, in_rob_jump_res});
      end
      m_full = (m_q.size() == QDEPTH);
    end
  end

  // compare process: every output, every cycle, mid-cycle
  logic       e_en, e_we, e_rdy, e_rv, e_jr, e_full, e_ovf, e_done, e_go, e_upd;
  logic [7:0] e_addr;
  logic [1:0] e_wd;
  always @(negedge clk) begin
    e_en = 1'b0; e_we = 1'b0; e_rdy = 1'b0; e_rv = 1'b0; e_jr = 1'b0;
    e_addr = 8'h00; e_wd = 2'b00; e_full = 1'b0; e_ovf = 1'b0; e_done = 1'b0;
    if (rst) begin
      e_go = rdy && !in_clear;
      if (m_init) begin
        e_en = e_go; e_we = e_go; e_addr = m_init_addr[7:0]; e_wd = INIT_V;
      end else if (m_wr) begin
        e_en = e_go; e_we = e_go; e_addr = m_wr_tag; e_wd = sat_ref(exp_tbl[m_wr_tag], m_wr_taken);
      end else begin
        e_upd = e_go && (m_q.size() > 0) && ((m_q.size() >= STARVE_TH) || !in_fetcher_valid);
        if (e_upd) begin
          e_en = 1'b1; e_addr = m_q[0][8:1];
        end else begin
          e_rdy = e_go; e_en = e_go && in_fetcher_valid; e_addr = in_fetcher_tag;
        end
      end
      e_rv = m_res && rdy && !in_clear;
      e_jr = e_rv && m_res_jmp;
      e_full = m_full; e_ovf = m_ovf; e_done = m_done;
    end
    chk("tbl_en", out_tbl_en, e_en);
    chk("tbl_we", out_tbl_we, e_we);
    if (e_en) chk("tbl_addr", out_tbl_addr, e_addr);
    if (e_we) chk("tbl_wdata", out_tbl_wdata, e_wd);
    chk("fetch_ready", out_fetcher_ready, e_rdy);
    chk("res_valid", out_fetcher_res_valid, e_rv);
    chk("jump_res", out_fetcher_jump_res, e_jr);
    chk("rob_full", out_rob_full, e_full);
    chk("overflow", out_overflow, e_ovf);
    chk("init_done", out_init_done, e_done);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, n, bad;
    tick(3);
    rst = 1'b1;
    tick(255);
    chk("init_done_at_255", out_init_done, 1'b0);
    tick();
    chk("init_done_at_256", out_init_done, 1'b1);

    // first lookup after init reads 01 -> not taken
    in_fetcher_valid = 1'b1; in_fetcher_tag = 8'h10;
    tick();
    in_fetcher_valid = 1'b0;
    chk("lookup0_valid", out_fetcher_res_valid, 1'b1);
    chk("lookup0_jump", out_fetcher_jump_res, 1'b0);

    // three taken updates saturate tag 0x10
    in_rob_bp_res = 1'b1; in_rob_tag = 8'h10; in_rob_jump_res = 1'b1;
    tick(3);
    in_rob_bp_res = 1'b0;
    tick(8);
    chk("tbl_10_sat", mem[8'h10], 2'b11);
    in_fetcher_valid = 1'b1; in_fetcher_tag = 8'h10;
    tick();
    in_fetcher_valid = 1'b0;
    chk("lookup10_jump", out_fetcher_jump_res, 1'b1);

    // four not-taken updates floor tag 0x22
    in_rob_bp_res = 1'b1; in_rob_tag = 8'h22; in_rob_jump_res = 1'b0;
    tick(4);
    in_rob_bp_res = 1'b0;
    tick(10);
    chk("tbl_22_floor", mem[8'h22], 2'b00);

    // fetch busy: updates wait until occupancy reaches the starvation threshold
    lows = 0;
    in_fetcher_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_fetcher_tag = 8'($urandom);
      in_rob_bp_res = (i < 3);
      in_rob_tag = 8'($urandom_range(0, 15));
      in_rob_jump_res = 1'($urandom);
      #1;
      if (!out_fetcher_ready) lows++;
      @(posedge clk); #1;
    end
    in_rob_bp_res = 1'b0; in_fetcher_valid = 1'b0;
    chk("starve_ready_low", lows, 2);
    tick(6);

    // clear, then overflow the FIFO during init and freeze mid-walk
    in_clear = 1'b1; tick(); in_clear = 1'b0;
    in_rob_bp_res = 1'b1; in_rob_tag = 8'h05; in_rob_jump_res = 1'b1;
    tick(4);
    chk("full_after_4", out_rob_full, 1'b1);
    chk("no_ovf_after_4", out_overflow, 1'b0);
    tick();
    in_rob_bp_res = 1'b0;
    chk("ovf_after_5", out_overflow, 1'b1);
    rdy = 1'b0;
    tick(10);
    chk("frozen_init_done", out_init_done, 1'b0);
    rdy = 1'b1;
    n = 0;
    while (!out_init_done && n < 400) begin tick(); n++; end
    chk("reinit_with_freeze_cycles", 15 + n, 266);
    tick(12);
    chk("ovf_sticky", out_overflow, 1'b1);

    // clear while the update write is pending
    in_rob_bp_res = 1'b1; in_rob_tag = 8'h33; in_rob_jump_res = 1'b0;
    tick();
    in_rob_bp_res = 1'b0;
    tick();
    in_clear = 1'b1;
    #1;
    chk("clear_blocks_write", out_tbl_en, 1'b0);
    tick();
    in_clear = 1'b0;
    chk("clear_ovf", out_overflow, 1'b0);
    chk("clear_done", out_init_done, 1'b0);
    chk("clear_full", out_rob_full, 1'b0);
    tick(255);
    chk("reinit_255", out_init_done, 1'b0);
    tick();
    chk("reinit_256", out_init_done, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rdy = ($urandom_range(0, 9) != 0);
      in_clear = ($urandom_range(0, 299) == 0);
      in_fetcher_valid = 1'($urandom);
      in_fetcher_tag = 8'($urandom_range(0, 15));
      in_rob_bp_res = ($urandom_range(0, 9) < 4);
      in_rob_tag = 8'($urandom_range(0, 15));
      in_rob_jump_res = 1'($urandom);
      if (i == 2000) begin
        rst = 1'b0; tick(2); rst = 1'b1;
      end
      tick();
    end
    in_clear = 1'b0; in_fetcher_valid = 1'b0; in_rob_bp_res = 1'b0; rdy = 1'b1;
    tick(20);

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_tbl[i]) bad++;
    chk("table_contents", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
